// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: field layout, opcode map,
// FSM states and the decoded-instruction payload.
package alu_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned RA_W  = 4;
  localparam int unsigned IMM_W = 16;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RD_MSB   = 25;
  localparam int unsigned RD_LSB   = 22;
  localparam int unsigned RS_MSB   = 21;
  localparam int unsigned RS_LSB   = 18;
  localparam int unsigned HL_BIT   = 17;
  localparam int unsigned RSVD_BIT = 16;
  localparam int unsigned VAL_MSB  = 15;

  localparam logic [OP_W-1:0] OP_ADD       = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB       = 6'd1;
  localparam logic [OP_W-1:0] OP_SHL       = 6'd2;
  localparam logic [OP_W-1:0] OP_SHR       = 6'd3;
  localparam logic [OP_W-1:0] OP_MOV4      = 6'd4;
  localparam logic [OP_W-1:0] OP_LDH       = 6'd5;
  localparam logic [OP_W-1:0] OP_MOV6      = 6'd6;
  localparam logic [OP_W-1:0] OP_MOV7      = 6'd7;
  localparam logic [OP_W-1:0] OP_CMP_FIRST = 6'd8;
  localparam logic [OP_W-1:0] OP_CMP_LAST  = 6'd13;
  localparam logic [OP_W-1:0] OP_JMP       = 6'd14;
  localparam logic [OP_W-1:0] OP_JMPC      = 6'd15;
  localparam logic [OP_W-1:0] OP_NOP       = 6'd63;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CL_WRITE   = 2'd0,
    CL_FLAG    = 2'd1,
    CL_BRANCH  = 2'd2,
    CL_ILLEGAL = 2'd3
  } iclass_e;

  typedef struct packed {
    iclass_e              cls;
    logic [OP_W-1:0]      opcode;
    logic [RA_W-1:0]      rd;
    logic [RA_W-1:0]      rs;
    logic                 highlow;
    logic [IMM_W-1:0]     value;
  } dec_t;

  // Opcodes are grouped in contiguous ranges, so the class is a range test.
  function automatic iclass_e op_class(input logic [OP_W-1:0] op);
    if (op <= OP_MOV7)          return CL_WRITE;
    else if (op <= OP_CMP_LAST) return CL_FLAG;
    else if (op <= OP_JMPC)     return CL_BRANCH;
    else                        return CL_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction-word splitter: IR -> class and ALU/regfile fields.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  output dec_t            dec_o
);

  logic unused_rsvd;
  assign unused_rsvd = ir_i[RSVD_BIT];

  always_comb begin
    dec_o         = '0;
    dec_o.cls     = op_class(ir_i[OP_MSB:OP_LSB]);
    dec_o.opcode  = ir_i[OP_MSB:OP_LSB];
    dec_o.rd      = ir_i[RD_MSB:RD_LSB];
    dec_o.rs      = ir_i[RS_MSB:RS_LSB];
    dec_o.highlow = ir_i[HL_BIT];
    dec_o.value   = ir_i[VAL_MSB:0];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/issue sequencer for the 32-bit ALU: fetches over req/ack,
// drives ALU and register-file controls, retires via writeback or PC update.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [RA_W-1:0]  rf_raddr_a,
  output logic [RA_W-1:0]  rf_raddr_b,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [OP_W-1:0]  alu_instr,
  output logic [IMM_W-1:0] alu_value,
  output logic             alu_highlow,
  output logic             alu_f1,
  output logic             alu_f2,
  input  logic [XLEN-1:0]  alu_c,
  input  logic             alu_f3,
  input  logic             alu_addrch,
  input  logic [XLEN-1:0]  alu_naddr,
  output logic [XLEN-1:0]  pc,
  output logic             retire,
  output logic             halted
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             f1_q, f1_d, f2_q, f2_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [RA_W-1:0]  waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [RA_W-1:0]  ra_q, ra_d, rb_q, rb_d;
  logic [OP_W-1:0]  instr_q, instr_d;
  logic [IMM_W-1:0] value_q, value_d;
  logic             hl_q, hl_d;
  logic             retire_q, retire_d;
  logic             halted_q, halted_d;

  logic             ir_load;
  logic [XLEN-1:0]  pc_seq;
  dec_t             dec;

  // An ack only counts once the request is actually visible on the bus.
  assign ir_load = (state_q == ST_FETCH) && req_q && imem_ack;
  assign ir_d    = ir_load ? imem_rdata : ir_q;
  assign pc_seq  = pc_q + XLEN'(PC_STEP);

  alu_seq_decode u_decode (
    .ir_i  (ir_d),
    .dec_o (dec)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    req_d    = 1'b0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ra_d     = '0;
    rb_d     = '0;
    instr_d  = OP_NOP;
    value_d  = '0;
    hl_d     = 1'b0;
    retire_d = 1'b0;
    halted_d = halted_q;

    unique case (state_q)
      ST_FETCH: begin
        req_d = 1'b1;
        if (ir_load) begin
          req_d   = 1'b0;
          state_d = ST_DECODE;
          ra_d    = dec.rd;
          rb_d    = dec.rs;
          instr_d = dec.opcode;
          value_d = dec.value;
          hl_d    = dec.highlow;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        ra_d    = dec.rd;
        rb_d    = dec.rs;
        instr_d = dec.opcode;
        value_d = dec.value;
        hl_d    = dec.highlow;
      end
      ST_EXEC: begin
        state_d  = ST_FETCH;
        req_d    = 1'b1;
        retire_d = 1'b1;
        unique case (dec.cls)
          CL_WRITE: begin
            we_d    = 1'b1;
            waddr_d = dec.rd;
            wdata_d = alu_c;
            pc_d    = pc_seq;
          end
          CL_FLAG: begin
            f2_d = f1_q;
            f1_d = alu_f3;
            pc_d = pc_seq;
          end
          CL_BRANCH: pc_d = alu_addrch ? alu_naddr : pc_seq;
          default: begin
            state_d  = ST_HALT;
            req_d    = 1'b0;
            retire_d = 1'b0;
            halted_d = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      pc_q     <= RESET_PC;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      instr_q  <= OP_NOP;
      value_q  <= '0;
      hl_q     <= 1'b0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      req_q    <= req_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      instr_q  <= instr_d;
      value_q  <= value_d;
      hl_q     <= hl_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign rf_raddr_a  = ra_q;
  assign rf_raddr_b  = rb_q;
  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign alu_instr   = instr_q;
  assign alu_value   = value_q;
  assign alu_highlow = hl_q;
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign pc          = pc_q;
  assign retire      = retire_q;
  assign halted      = halted_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction fetch/decode/issue sequencer that drives the 32-bit ALU. Fetches instruction words over a req/ack handshake, decodes them into the ALU's `instr`/`value`/`highlow` controls and register-file read/write strobes, and retires each instruction by writing the ALU result back or updating the program counter from the ALU's `addrch`/`naddr` branch outputs. Sits between instruction memory, the register file and the ALU. It is the issuing side of the ALU control interface.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `PC_STEP`, 1: PC increment per sequential instruction (word addressing).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, held until ack.
- `imem_addr` out 32: fetch address (= `pc`).
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `rf_raddr_a`, `rf_raddr_b` out 4: register read addresses (ALU A, B).
- `rf_we` out 1: register write strobe (one cycle).
- `rf_waddr` out 4: write address.
- `rf_wdata` out 32: write data.
- `alu_instr` out 6: ALU opcode.
- `alu_value` out 16: immediate.
- `alu_highlow` out 1: immediate half select (1 = upper).
- `alu_f1`, `alu_f2` out 1: flag register bits to ALU.
- `alu_c` in 32: ALU result.
- `alu_f3` in 1: ALU compare result.
- `alu_addrch` in 1: branch taken.
- `alu_naddr` in 32: branch target.
- `pc` out 32: current PC.
- `retire` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: sticky, set on illegal opcode.

## Operation
- Instruction word: [31:26] opcode, [25:22] rd (A source and destination), [21:18] rs (B source), [17] highlow, [16] reserved (ignored), [15:0] value.
- Opcode classes:
  - 0–7 (add, sub, shl, shr, move 4/6/7, load-half 5): write `alu_c` to rd.
  - 8–13 (compares/flag tests): `f2 <= f1; f1 <= alu_f3`; no write.
  - 14, 15 (jump, conditional jump): if `alu_addrch`, `pc <= alu_naddr`, else `pc <= pc + PC_STEP`.
  - 16–63: illegal; enter HALT.
- Non-branch instructions set `pc <= pc + PC_STEP`, 32-bit wrapping (32'hFFFF_FFFF + 1 → 0).
- FSM states FETCH, DECODE, EXEC, HALT; reset → FETCH.
  - FETCH: `imem_req=1`. On `imem_ack`, latch `imem_rdata` into IR → DECODE. No ack → stay, with `imem_addr` stable.
  - DECODE: drive `rf_raddr_a`=rd, `rf_raddr_b`=rs, and `alu_*` from IR. Register file and ALU are combinational; results settle this cycle → EXEC.
  - EXEC: same drives held. Sample `alu_c`/`alu_f3`/`alu_addrch`/`alu_naddr`; do writeback/flag/PC update; pulse `retire` → FETCH. Illegal opcode: no writeback, no PC change, `halted<=1` → HALT.
  - HALT: absorbing until reset; all strobes 0.
- Outside DECODE/EXEC, `alu_instr` = 6'd63 (no-op class: ALU C = 0, no branch).

## Timing
- Reset values: `pc`=RESET_PC, IR=0, f1=f2=0, `imem_req`=0 during reset then 1 on the first clock in FETCH, `rf_we`=0, `retire`=0, `halted`=0, `alu_instr`=63, `alu_value`=0, `alu_highlow`=0, read/write addresses 0.
- Instruction latency: 3 cycles with zero-wait ack (FETCH ack cycle, DECODE, EXEC); +1 per wait cycle.
- `rf_we`, `retire`, and the PC/flag update all occur on the single EXEC→FETCH clock edge. `rf_we` and `rf_wdata` are registered outputs, valid the cycle after EXEC; the register file writes on the following edge.
- Next fetch issues `imem_addr` = updated PC the cycle after EXEC.
- `imem_ack` outside FETCH is ignored.
- Reset asserted mid-instruction: immediate return to reset values; no partial writeback.
- Writeback to rd=rs: read-before-write semantics; the next instruction sees the new value.

## Structure
- Shared package `alu_seq_pkg`: opcode constants (OP_ADD=0 … OP_JMPC=15, OP_NOP=63), field bit positions, state enum.
- One sub-module, `alu_seq_decode`, is natural: combinational IR → {class, rd, rs, highlow, value}.

## Test plan
- Reset, IR `add r1,r2` (opcode 0, r1=5, r2=7) with zero-wait ack → `rf_we` with `rf_waddr`=1, `rf_wdata`=12; `pc` 0→1; `retire` 3 cycles after first req.
- `imem_ack` delayed 4 cycles → `imem_addr` stable, `imem_req` held; retire at cycle 7.
- Compare op 8 with A==B, then op 15 with `alu_addrch`=1, `naddr`=0x40 → f1=1, no `rf_we`, `pc`=0x40.
- Opcode 14 with `alu_addrch`=0 → `pc`=old+1. With RESET_PC=32'hFFFF_FFFF and a non-branch instruction → `pc`=0.
- Opcode 20 → `halted`=1, no `retire`, `imem_req` stays 0 thereafter; `reset_n` pulse → FETCH at RESET_PC.
- `reset_n` low during EXEC of a write → no `rf_we`, all outputs at reset values asynchronously.
